// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the CPU and the loader,
// serialising accesses with round-robin arbitration and a one-cycle acknowledge.
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner,
    output logic [7:0]        conflict_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    state_t state;
    logic [2:0] wait_cnt;
    logic lat_we;
    logic both;
    logic grant;
    assign both = cpu_req & ldr_req;
    // on a tie the port that did not own the previous grant wins
    assign grant = both ? ~owner : ldr_req;
    assign busy = state != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wait_cnt <= '0;
            lat_we <= 1'b0;
            owner <= 1'b1;
            conflict_cnt <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                IDLE: if (cpu_req | ldr_req) begin
                    state <= ISSUE;
                    owner <= grant;
                    lat_we <= grant ? ldr_we : cpu_we;
                    mem_en <= 1'b1;
                    mem_we <= grant ? ldr_we : cpu_we;
                    mem_addr <= grant ? ldr_addr : cpu_addr;
                    mem_wdata <= grant ? ldr_wdata : cpu_wdata;
                    if (both && conflict_cnt != 8'hFF) conflict_cnt <= conflict_cnt + 8'd1;
                end
                ISSUE: begin
                    state <= WAIT;
                    wait_cnt <= 3'(MEM_LATENCY - 1);
                end
                WAIT: if (wait_cnt == '0) begin
                    state <= ACK;
                    cpu_ack <= ~owner;
                    ldr_ack <= owner;
                    if (!lat_we && owner) ldr_rdata <= mem_rdata;
                    if (!lat_we && !owner) cpu_rdata <= mem_rdata;
                end else begin
                    wait_cnt <= wait_cnt - 3'd1;
                end
                ACK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized transaction-level check of data_mem_arbiter,
// one instance at MEM_LATENCY 1 and one at MEM_LATENCY 3 running side by side.
module tb_data_mem_arbiter;
    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } op_t;
    logic clk = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic op_t rnd_op();
        return {1'($urandom), 4'h0, 4'($urandom), 8'($urandom)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int L = g ? 3 : 1;
        logic reset, cpu_req, cpu_we, cpu_ack, ldr_req, ldr_we, ldr_ack;
        logic mem_en, mem_we, busy, owner, done, pl_en;
        logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, ldr_addr, ldr_wdata, ldr_rdata;
        logic [7:0] mem_addr, mem_wdata, mem_rdata, conflict_cnt;
        logic [7:0] pl_addr, pl_data, rd_val, junk;
        logic [7:0] mem [256];
        logic [7:0] ref_mem [256];
        logic [7:0] exp_crd, exp_lrd;
        logic last_owner;
        int exp_conf;
        int rd_cnt = 0;
        op_t cq[$];
        op_t lq[$];

        data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LATENCY(L)) dut (
            .clk(clk), .reset(reset),
            .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
            .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
            .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
            .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata), .busy(busy), .owner(owner), .conflict_cnt(conflict_cnt)
        );

        // memory device: read data is valid only in the cycle 1+L after mem_en, garbage otherwise
        always @(posedge clk) begin
            if (pl_en) mem[pl_addr] <= pl_data;
            else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) begin
                rd_val <= mem[mem_addr];
                rd_cnt <= L;
            end else if (rd_cnt > 0) begin
                rd_cnt <= rd_cnt - 1;
            end
            junk <= 8'($urandom);
        end
        assign mem_rdata = rd_cnt == 1 ? rd_val : junk;

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic drive();
            cpu_req = cq.size() != 0;
            if (cq.size() != 0) {cpu_we, cpu_addr, cpu_wdata} = cq[0];
            ldr_req = lq.size() != 0;
            if (lq.size() != 0) {ldr_we, ldr_addr, ldr_wdata} = lq[0];
        endtask

        task automatic chk_reset(input string t);
            chk({t, " acks"}, {cpu_ack, ldr_ack}, 0);
            chk({t, " mem pins"}, {mem_en, mem_we, mem_addr, mem_wdata}, 0);
            chk({t, " busy"}, busy, 0);
            chk({t, " owner"}, owner, 1);
            chk({t, " rdata"}, {cpu_rdata, ldr_rdata}, 0);
            chk({t, " conflict_cnt"}, conflict_cnt, 0);
        endtask

        task automatic model_reset();
            last_owner = 1'b1;
            exp_conf = 0;
            exp_crd = 8'h00;
            exp_lrd = 8'h00;
        endtask

        // serve both queues to completion; each access is checked against the grant rule and fixed latency
        task automatic run();
            drive();
            while (cq.size() != 0 || lq.size() != 0) begin
                logic gr, both;
                op_t op;
                both = cq.size() != 0 && lq.size() != 0;
                gr = both ? !last_owner : lq.size() != 0;
                if (both && exp_conf < 255) exp_conf++;
                last_owner = gr;
                op = gr ? lq[0] : cq[0];
                for (int k = 1; k <= 2 + L; k++) begin
                    tick();
                    chk("mem_en", mem_en, k == 1);
                    chk("busy", busy, 1);
                    chk("cpu_ack", cpu_ack, k == 2 + L && !gr);
                    chk("ldr_ack", ldr_ack, k == 2 + L && gr);
                    if (k == 1) begin
                        chk("mem_we", mem_we, op.we);
                        chk("mem_addr", mem_addr, op.addr);
                        chk("mem_wdata", mem_wdata, op.wdata);
                    end else begin
                        chk("mem_we idle", mem_we, 0);
                    end
                end
                if (op.we) ref_mem[op.addr] = op.wdata;
                else if (gr) exp_lrd = ref_mem[op.addr];
                else exp_crd = ref_mem[op.addr];
                chk("owner", owner, gr);
                chk("cpu_rdata", cpu_rdata, exp_crd);
                chk("ldr_rdata", ldr_rdata, exp_lrd);
                if (gr) void'(lq.pop_front());
                else void'(cq.pop_front());
                drive();
                tick();
                chk("idle pins", {busy, mem_en, mem_we, cpu_ack, ldr_ack}, 0);
                chk("conflict_cnt", conflict_cnt, exp_conf);
            end
        endtask

        task automatic reset_in_wait();
            cq.push_back({1'b0, 8'h07, 8'h00});
            drive();
            tick();
            tick();
            reset = 1'b1;
            #1;
            chk_reset("wait reset");
            tick();
            chk("wait reset cpu_ack", cpu_ack, 0);
            reset = 1'b0;
            model_reset();
            run();
        endtask

        initial begin
            done = 1'b0;
            reset = 1'b1;
            pl_en = 1'b1;
            {cpu_req, cpu_we, cpu_addr, cpu_wdata} = '0;
            {ldr_req, ldr_we, ldr_addr, ldr_wdata} = '0;
            for (int i = 0; i < 256; i++) begin
                pl_addr = 8'(i);
                pl_data = i == 16 ? 8'hA5 : 8'($urandom);
                ref_mem[i] = pl_data;
                tick();
            end
            pl_en = 1'b0;
            chk_reset("reset");
            reset = 1'b0;
            model_reset();
            tick();
            for (int i = 0; i < 4; i++) begin
                cq.push_back(rnd_op());
                lq.push_back(rnd_op());
            end
            run();
            chk("contention conflict_cnt", conflict_cnt, 7);
            cq.push_back({1'b0, 8'h10, 8'h00});
            run();
            chk("directed cpu read", cpu_rdata, 8'hA5);
            lq.push_back({1'b1, 8'h20, 8'h3C});
            run();
            cq.push_back({1'b0, 8'h20, 8'h00});
            run();
            chk("directed read after write", cpu_rdata, 8'h3C);
            repeat (20) begin
                repeat ($urandom_range(0, 3)) cq.push_back(rnd_op());
                repeat ($urandom_range(0, 3)) lq.push_back(rnd_op());
                run();
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    chk("gap idle", {busy, mem_en, cpu_ack, ldr_ack}, 0);
                end
            end
            reset_in_wait();
            repeat (150) begin
                cq.push_back(rnd_op());
                lq.push_back(rnd_op());
            end
            run();
            chk("saturated", conflict_cnt, 255);
            repeat (2) begin
                cq.push_back(rnd_op());
                lq.push_back(rnd_op());
            end
            run();
            chk("saturation hold", conflict_cnt, 255);
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 40000 && !(u[0].done === 1'b1 && u[1].done === 1'b1); i++) @(posedge clk);
        chk("finished", {u[0].done, u[1].done}, 2'b11);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
